// File: rtl/regfile_mp.sv
// Multi-port register file: three registered read ports, two write ports (B wins), busy scoreboard.
// Optional REGFILE_BYPASS_EN: reads see same-edge writes/reservations (write-first); default is read-before-write.
module regfile_mp #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int ZERO_REG0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data0,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_busy0,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [WIDTH-1:0]  wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [WIDTH-1:0]  wr_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [WIDTH-1:0]  rd_data_q [3];
  logic [WIDTH-1:0]  rd_data_d [3];
  logic [2:0]        rd_busy_q;
  logic [2:0]        rd_busy_d;

  logic wa_ok, wb_ok, rsv_ok;

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;
  assign rd_addr[2] = rd_addr2;

  // Accesses to r0 are suppressed entirely when it is hardwired to zero.
  assign wa_ok  = wr_en_a && !((ZERO_REG0 != 0) && (wr_addr_a == '0));
  assign wb_ok  = wr_en_b && !((ZERO_REG0 != 0) && (wr_addr_b == '0));
  assign rsv_ok = rsv_en  && !((ZERO_REG0 != 0) && (rsv_addr  == '0));

  // Order matters: B overrides A, and a reservation overrides a write's busy clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wa_ok) begin
      mem_d[wr_addr_a]  = wr_data_a;
      busy_d[wr_addr_a] = 1'b0;
    end
    if (wb_ok) begin
      mem_d[wr_addr_b]  = wr_data_b;
      busy_d[wr_addr_b] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data_d[p] = '0;
      rd_busy_d[p] = 1'b0;
      if (!((ZERO_REG0 != 0) && (rd_addr[p] == '0))) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_d[p] = mem_d[rd_addr[p]];
        rd_busy_d[p] = busy_d[rd_addr[p]];
`else
        rd_data_d[p] = mem_q[rd_addr[p]];
        rd_busy_d[p] = busy_q[rd_addr[p]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      for (int p = 0; p < 3; p++) begin
        rd_data_q[p] <= '0;
      end
      rd_busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
      for (int p = 0; p < 3; p++) begin
        rd_data_q[p] <= rd_data_d[p];
      end
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data0 = rd_data_q[0];
  assign rd_data1 = rd_data_q[1];
  assign rd_data2 = rd_data_q[2];
  assign rd_busy0 = rd_busy_q[0];
  assign rd_busy1 = rd_busy_q[1];
  assign rd_busy2 = rd_busy_q[2];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios followed by random traffic, checked against an array-based model.
module tb_regfile_mp;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    rd_addr0, rd_addr1, rd_addr2;
  logic [WIDTH-1:0] rd_data0, rd_data1, rd_data2;
  logic             rd_busy0, rd_busy1, rd_busy2;
  logic             wr_en_a, wr_en_b, rsv_en;
  logic [AW-1:0]    wr_addr_a, wr_addr_b, rsv_addr;
  logic [WIDTH-1:0] wr_data_a, wr_data_b;
  logic [DEPTH-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state: register contents, pending-result flags, expected read outputs.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_busy [DEPTH];
  logic [WIDTH-1:0] m_rd [3];
  bit               m_rb [3];

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG0(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy0(rd_busy0), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; rsv_en = 1'b0;
  endtask

  // Apply the architectural rules for one edge, using the inputs the bench is driving.
  task automatic model_edge();
    logic [WIDTH-1:0] nm [DEPTH];
    bit               nb [DEPTH];
    logic [AW-1:0]    ra [3];
    ra[0] = rd_addr0; ra[1] = rd_addr1; ra[2] = rd_addr2;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
      for (int p = 0; p < 3; p++) begin m_rd[p] = '0; m_rb[p] = 0; end
      return;
    end
    nm = m_mem; nb = m_busy;
    if (wr_en_a && wr_addr_a != 0) begin nm[wr_addr_a] = wr_data_a; nb[wr_addr_a] = 0; end
    if (wr_en_b && wr_addr_b != 0) begin nm[wr_addr_b] = wr_data_b; nb[wr_addr_b] = 0; end
    if (rsv_en && rsv_addr != 0) nb[rsv_addr] = 1;
    for (int p = 0; p < 3; p++) begin
      if (ra[p] == 0) begin
        m_rd[p] = '0; m_rb[p] = 0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        m_rd[p] = nm[ra[p]]; m_rb[p] = nb[ra[p]];
`else
        m_rd[p] = m_mem[ra[p]]; m_rb[p] = m_busy[ra[p]];
`endif
      end
    end
    m_mem = nm; m_busy = nb;
  endtask

  task automatic check_all();
    logic [DEPTH-1:0] bv;
    for (int i = 0; i < DEPTH; i++) bv[i] = m_busy[i];
    chk("rd_data0", 32'(rd_data0), 32'(m_rd[0]));
    chk("rd_data1", 32'(rd_data1), 32'(m_rd[1]));
    chk("rd_data2", 32'(rd_data2), 32'(m_rd[2]));
    chk("rd_busy0", 32'(rd_busy0), 32'(m_rb[0]));
    chk("rd_busy1", 32'(rd_busy1), 32'(m_rb[1]));
    chk("rd_busy2", 32'(rd_busy2), 32'(m_rb[2]));
    chk("busy_vec", 32'(busy_vec), 32'(bv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rd_all(input logic [AW-1:0] a);
    rd_addr0 = a; rd_addr1 = a; rd_addr2 = a;
  endtask

  initial begin
    idle();
    rd_all('0);
    wr_addr_a = '0; wr_addr_b = '0; rsv_addr = '0;
    wr_data_a = '0; wr_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    for (int p = 0; p < 3; p++) begin m_rd[p] = '0; m_rb[p] = 0; end

    // Power-on reset
    rst = 1'b1; tick(); tick();
    idle();
    chk("reset_busy_vec", 32'(busy_vec), 32'h0);

    // Reset discards the state and a same-cycle write
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 16'hBEEF; rsv_en = 1'b1; rsv_addr = 4'd11; tick();
    idle();
    rst = 1'b1; wr_en_a = 1'b1; wr_addr_a = 4'd6; wr_data_a = 16'h5A5A; tick();
    idle(); rd_addr0 = 4'd5; tick();
    chk("reset_r5", 32'(rd_data0), 32'h0);
    rd_addr0 = 4'd6; tick();
    chk("reset_r6", 32'(rd_data0), 32'h0);
    chk("reset_busy_clear", 32'(busy_vec), 32'h0);

    // Read latency
    rd_all(4'd1);
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 16'h1234; tick();
    idle(); rd_all(4'd3);
    chk("lat_before", 32'(rd_data0), 32'h0);
    tick();
    chk("lat_p0", 32'(rd_data0), 32'h1234);
    chk("lat_p1", 32'(rd_data1), 32'h1234);
    chk("lat_p2", 32'(rd_data2), 32'h1234);

    // Dual-write collision: port B wins
    wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 16'hAAAA;
    wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 16'hBBBB; tick();
    idle(); rd_all(4'd7); tick();
    chk("collision", 32'(rd_data1), 32'hBBBB);

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 4'd9; tick();
    idle();
    chk("rsv_vec", 32'(busy_vec[9]), 32'h1);
    rd_all(4'd9); tick();
    chk("rsv_rd_busy", 32'(rd_busy0), 32'h1);
    wr_en_a = 1'b1; wr_addr_a = 4'd9; wr_data_a = 16'h0042; tick();
    idle();
    chk("wr_clears_busy", 32'(busy_vec[9]), 32'h0);
    tick();
    chk("wr_data_r9", 32'(rd_data2), 32'h0042);
    chk("wr_rd_busy", 32'(rd_busy2), 32'h0);
    wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 16'h0077; rsv_en = 1'b1; rsv_addr = 4'd9; tick();
    idle();
    chk("rsv_beats_wr", 32'(busy_vec[9]), 32'h1);
    tick();
    chk("rsv_wr_data", 32'(rd_data0), 32'h0077);

    // Same-cycle read/write
    rd_all(4'd1);
    wr_en_a = 1'b1; wr_addr_a = 4'd4; wr_data_a = 16'h1111; tick();
    wr_data_a = 16'h2222; rd_all(4'd4); tick();
    idle();
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rw", 32'(rd_data0), 32'h2222);
`else
    chk("same_cycle_rw", 32'(rd_data0), 32'h1111);
`endif
    tick();
    chk("after_rw", 32'(rd_data0), 32'h2222);

    // Zero register
    wr_en_a = 1'b1; wr_addr_a = 4'd0; wr_data_a = 16'hFFFF;
    wr_en_b = 1'b1; wr_addr_b = 4'd0; wr_data_b = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0; rd_all(4'd0); tick();
    idle(); tick();
    chk("r0_data", 32'(rd_data1), 32'h0);
    chk("r0_busy", 32'(rd_busy1), 32'h0);
    chk("r0_vec", 32'(busy_vec[0]), 32'h0);

    // Random traffic; narrow address range in some cycles to force collisions
    for (int n = 0; n < 400; n++) begin
      int amax;
      amax = ($urandom_range(0, 3) == 0) ? 3 : DEPTH - 1;
      rst       = ($urandom_range(0, 60) == 0);
      wr_en_a   = $urandom_range(0, 1);
      wr_en_b   = $urandom_range(0, 2) == 0;
      rsv_en    = $urandom_range(0, 2) == 0;
      wr_addr_a = AW'($urandom_range(0, amax));
      wr_addr_b = AW'($urandom_range(0, amax));
      rsv_addr  = AW'($urandom_range(0, amax));
      wr_data_a = WIDTH'($urandom);
      wr_data_b = WIDTH'($urandom);
      rd_addr0  = AW'($urandom_range(0, amax));
      rd_addr1  = AW'($urandom_range(0, amax));
      rd_addr2  = AW'($urandom_range(0, amax));
      tick();
    end
    idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
